// File: rtl/frac_dec_coeff_ctrl.sv
// Coefficient update controller for a fractional decimator.
// Writes land in a shadow bank while the controller is idle. The final write
// starts the update sequence: drain the datapath, commit the bank to the
// decimator in one strobe, then read every tap back and flag any mismatch.
// The decimator runs in bypass for the whole sequence so no samples are lost.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | accepting shadow writes, cfg_ready high
// ST_DRAIN  | DRAIN_CYC cycles for the decimator datapath to empty
// ST_COMMIT | single-cycle coeff_wr_en strobe to the decimator
// ST_VERIFY | one tap per cycle, readback compared against the shadow bank
module frac_dec_coeff_ctrl #(
   parameter int COEFF_WIDTH = 20,
   parameter int N_TAP       = 72,
   parameter int ADDR_WIDTH  = 7,
   parameter int DRAIN_CYC   = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                cfg_valid,
   output logic                                cfg_ready,
   input  logic [ADDR_WIDTH-1:0]               cfg_addr,
   input  logic [COEFF_WIDTH-1:0]              cfg_data,
   input  logic                                cfg_last,
   input  logic                                err_clr,
   input  logic                                s_valid_in,
   input  logic                                bypass_req,
   output logic                                dec_valid_in,
   output logic                                dec_bypass,
   output logic                                coeff_wr_en,
   output logic [N_TAP-1:0][COEFF_WIDTH-1:0]   coeff_data_in,
   input  logic [N_TAP-1:0][COEFF_WIDTH-1:0]   coeff_data_out,
   output logic                                busy,
   output logic                                done,
   output logic                                addr_err,
   output logic                                verify_err
);

   typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_COMMIT, ST_VERIFY} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_TAP   = ADDR_WIDTH'(N_TAP - 1);
   localparam logic [ADDR_WIDTH-1:0] DRAIN_LAST = ADDR_WIDTH'(DRAIN_CYC - 1);

   state_t                             state;
   state_t                             state_nxt;
   logic [N_TAP-1:0][COEFF_WIDTH-1:0]  shadow;
   logic [ADDR_WIDTH-1:0]              drain_cnt;
   logic [ADDR_WIDTH-1:0]              tap_cnt;
   logic                               wr_acc;
   logic                               addr_ok;
   logic                               tap_last;
   logic                               verify_miss;

   assign wr_acc       = cfg_valid && cfg_ready;
   assign addr_ok      = (cfg_addr <= LAST_TAP);
   assign tap_last     = (tap_cnt == LAST_TAP);
   assign verify_miss  = (state == ST_VERIFY) && (coeff_data_out[tap_cnt] != shadow[tap_cnt]);

   assign dec_valid_in  = s_valid_in;
   assign coeff_data_in = shadow;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      state_nxt   = state;
      cfg_ready   = 1'b0;
      busy        = 1'b1;
      coeff_wr_en = 1'b0;
      done        = 1'b0;
      unique case (state)
         ST_IDLE: begin
            cfg_ready = 1'b1;
            busy      = 1'b0;
            if (wr_acc && cfg_last) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (drain_cnt == DRAIN_LAST) state_nxt = ST_COMMIT;
         end
         ST_COMMIT: begin
            coeff_wr_en = 1'b1;
            state_nxt   = ST_VERIFY;
         end
         ST_VERIFY: begin
            if (tap_last) begin
               done      = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      dec_bypass = bypass_req | busy;
   end

   // Drain and tap counters, reloaded to zero as their state is entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drain_cnt <= '0;
         tap_cnt   <= '0;
      end else begin
         if (state == ST_IDLE && wr_acc && cfg_last) drain_cnt <= '0;
         else if (state == ST_DRAIN)                 drain_cnt <= drain_cnt + 1'b1;
         if (state == ST_COMMIT)                     tap_cnt <= '0;
         else if (state == ST_VERIFY && !tap_last)   tap_cnt <= tap_cnt + 1'b1;
      end
   end

   // Shadow bank; wr_acc is only possible in IDLE, so the bank is frozen mid-update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                shadow <= '0;
      else if (wr_acc && addr_ok) shadow[cfg_addr] <= cfg_data;
   end

   // Sticky error flags; a new error in the same cycle beats err_clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_err   <= 1'b0;
         verify_err <= 1'b0;
      end else begin
         if (wr_acc && !addr_ok) addr_err <= 1'b1;
         else if (err_clr)       addr_err <= 1'b0;
         if (verify_miss)        verify_err <= 1'b1;
         else if (err_clr)       verify_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_frac_dec_coeff_ctrl.sv
module tb_frac_dec_coeff_ctrl;
   localparam int CW = 20;
   localparam int NT = 72;
   localparam int AW = 7;
   localparam int DC = 4;

   logic clk = 1'b0;
   logic rst_n, cfg_valid, cfg_ready, cfg_last, err_clr, s_valid_in, bypass_req;
   logic [AW-1:0] cfg_addr;
   logic [CW-1:0] cfg_data;
   logic dec_valid_in, dec_bypass, coeff_wr_en, busy, done, addr_err, verify_err;
   logic [NT-1:0][CW-1:0] coeff_data_in;
   logic [NT-1:0][CW-1:0] coeff_data_out;
   logic [NT-1:0][CW-1:0] dec_bank = '0;
   logic fault_en = 1'b0;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic verr;
      logic aerr;
   } exp_t;
   exp_t sb_q[$];

   logic [CW-1:0] model [NT];

   int busy_cnt = 0, seq_wr = 0, wr_at = 0, bypass_bad = 0, valid_bad = 0, wr_total = 0;
   bit post_done = 0;

   frac_dec_coeff_ctrl #(.COEFF_WIDTH(CW), .N_TAP(NT), .ADDR_WIDTH(AW), .DRAIN_CYC(DC)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_last(cfg_last), .err_clr(err_clr),
      .s_valid_in(s_valid_in), .bypass_req(bypass_req), .dec_valid_in(dec_valid_in),
      .dec_bypass(dec_bypass), .coeff_wr_en(coeff_wr_en), .coeff_data_in(coeff_data_in),
      .coeff_data_out(coeff_data_out), .busy(busy), .done(done),
      .addr_err(addr_err), .verify_err(verify_err)
   );

   always #5 clk = ~clk;

   // Decimator coefficient store; it is not reset, it keeps its last committed bank.
   always @(posedge clk) if (coeff_wr_en) dec_bank <= coeff_data_in;

   // Readback path with an optional stuck-at-zero fault on tap 17.
   always_comb begin
      coeff_data_out = dec_bank;
      if (fault_en) coeff_data_out[17] = '0;
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_shadow(input string name);
      int m = 0;
      for (int k = 0; k < NT; k++) if (coeff_data_in[k] !== model[k]) m++;
      check(name, m, 0);
   endtask

   task automatic cfg_write(input int a, input int d, input bit last);
      int n = 0;
      cfg_valid = 1'b1;
      cfg_addr  = AW'(a);
      cfg_data  = CW'(d);
      cfg_last  = last;
      @(negedge clk);
      while (!cfg_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cfg_ready) check("write_timeout", 0, 1);
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
      if (a < NT) model[a] = CW'(d);
   endtask

   task automatic wait_done();
      int n = 0;
      while (n < 300) begin
         @(negedge clk);
         if (done) break;
         n++;
      end
      if (!done) check("done_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   // Monitor: tracks each update sequence and scores it when done appears.
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_cnt = 0; seq_wr = 0; wr_at = 0; bypass_bad = 0; post_done = 0;
      end else begin
         if (dec_valid_in !== s_valid_in) valid_bad++;
         if (busy) begin
            busy_cnt++;
            if (dec_bypass !== 1'b1) bypass_bad++;
         end else if (dec_bypass !== bypass_req) bypass_bad++;
         if (coeff_wr_en) begin
            wr_total++;
            seq_wr++;
            wr_at = busy_cnt;
         end
         if (done) begin
            if (sb_q.size() == 0) check("unexpected_done", 1, 0);
            else begin
               exp_t e;
               e = sb_q.pop_front();
               check("busy_cycles", busy_cnt, DC + 1 + NT);
               check("wr_en_pulses", seq_wr, 1);
               check("wr_en_position", wr_at, DC + 1);
               check("bypass_during_update", bypass_bad, 0);
               check("verify_err_at_done", int'(verify_err), int'(e.verr));
               check("addr_err_at_done", int'(addr_err), int'(e.aerr));
            end
            busy_cnt = 0; seq_wr = 0; wr_at = 0; bypass_bad = 0;
            post_done = 1;
         end else if (post_done) begin
            post_done = 0;
            check("idle_after_done", int'({busy, done, cfg_ready}), 1);
         end
      end
   end

   initial begin
      rst_n = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_last = 1'b0;
      err_clr = 1'b0; s_valid_in = 1'b1; bypass_req = 1'b1;
      for (int k = 0; k < NT; k++) model[k] = '0;

      // Reset values
      #12;
      check("rst_outputs", int'({busy, done, coeff_wr_en, addr_err, verify_err, cfg_ready}), 1);
      check("rst_bypass_follows_req_1", int'(dec_bypass), 1);
      bypass_req = 1'b0;
      #1;
      check("rst_bypass_follows_req_0", int'(dec_bypass), 0);
      check_shadow("rst_shadow_zero");
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic load of all taps, plus a write attempt while busy that must be ignored
      sb_q.push_back('{verr: 1'b0, aerr: 1'b0});
      for (int k = 0; k < NT; k++) cfg_write(k, 1000 + k, k == NT - 1);
      check("busy_after_last", int'({busy, cfg_ready}), 2);
      cfg_valid = 1'b1; cfg_addr = 7'd3; cfg_data = 20'd7;
      @(posedge clk); @(posedge clk); #1;
      cfg_valid = 1'b0;
      check_shadow("shadow_frozen_while_busy");
      wait_done();
      check("verify_err_clean", int'(verify_err), 0);
      check_shadow("shadow_basic_load");

      // Out-of-range address
      cfg_write(NT, 5, 1'b0);
      check("addr_err_set", int'(addr_err), 1);
      check("no_start_on_bad_addr", int'(busy), 0);
      check_shadow("shadow_unchanged_bad_addr");
      err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
      check("addr_err_cleared", int'(addr_err), 0);

      // Readback fault on tap 17
      sb_q.push_back('{verr: 1'b1, aerr: 1'b0});
      cfg_write(17, 123, 1'b1);
      fault_en = 1'b1;
      wait_done();
      check("verify_err_sticky", int'(verify_err), 1);
      fault_en = 1'b0;
      err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
      check("verify_err_cleared", int'(verify_err), 0);

      // Bad address on the last write still starts the sequence
      sb_q.push_back('{verr: 1'b0, aerr: 1'b1});
      cfg_write(127, 9, 1'b1);
      check("bad_last_starts", int'(busy), 1);
      wait_done();
      check_shadow("shadow_after_bad_last");
      err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;

      // Error beats clear in the same cycle
      err_clr = 1'b1;
      cfg_write(100, 1, 1'b0);
      err_clr = 1'b0;
      check("err_beats_clr", int'(addr_err), 1);
      err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;

      // Reset two cycles into DRAIN aborts the update
      cfg_write(5, 55, 1'b1);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b0;
      for (int k = 0; k < NT; k++) model[k] = '0;
      #2;
      check("midrst_outputs", int'({busy, done, coeff_wr_en, addr_err, verify_err, cfg_ready}), 1);
      check("midrst_bypass", int'(dec_bypass), 0);
      check_shadow("midrst_shadow_zero");
      begin
         int wr_before;
         wr_before = wr_total;
         repeat (3) @(posedge clk);
         #1; rst_n = 1'b1;
         repeat (12) @(posedge clk);
         #1;
         check("midrst_no_wr_en", wr_total, wr_before);
      end
      check("midrst_ready_after", int'({busy, cfg_ready}), 1);
      check("dec_keeps_coeffs", int'(dec_bank[17]), 123);

      check("scoreboard_drained", sb_q.size(), 0);
      check("valid_never_gated", valid_bad, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
